// File: rtl/regfile_sb_if.sv
// Bus between decode and the register file with scoreboard.
// Read side:  rs_i (packed per-port addresses), rd_data_o, rs_busy_o.
// Write-back: wb_valid_i, wb_rd_i, wb_data_i.
// Issue/flush: issue_valid_i, issue_rd_i, flush_i; status busy_count_o.
// master = decode/pipeline side, slave = register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rs_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]      rs_busy_o;
  logic                   wb_valid_i;
  logic [AW-1:0]          wb_rd_i;
  logic [XLEN-1:0]        wb_data_i;
  logic                   issue_valid_i;
  logic [AW-1:0]          issue_rd_i;
  logic                   flush_i;
  logic [AW:0]            busy_count_o;

  modport master (
    output rs_i, wb_valid_i, wb_rd_i, wb_data_i, issue_valid_i, issue_rd_i, flush_i,
    input  rd_data_o, rs_busy_o, busy_count_o
  );

  modport slave (
    input  rs_i, wb_valid_i, wb_rd_i, wb_data_i, issue_valid_i, issue_rd_i, flush_i,
    output rd_data_o, rs_busy_o, busy_count_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with write-back scoreboard.
// Ports: clk, reset (async active-low), bus (regfile_sb_if.slave).
// Reads are combinational with optional same-cycle write-back forwarding;
// busy bits are set by issue, cleared by write-back, all cleared by flush.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]        regs_q [NREGS];
  logic [XLEN-1:0]        regs_d [NREGS];
  logic [NREGS-1:0]       busy_q;
  logic [NREGS-1:0]       busy_d;
  logic [CW-1:0]          busy_count_q;
  logic [CW-1:0]          busy_count_d;
  logic                   wb_en;
  logic                   issue_en;
  logic [AW-1:0]          rs_sel;
  logic                   wb_hit;
  logic                   issue_hit;
  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rs_busy_c;

  // Strobes are ignored while reset is asserted (also blocks forwarding).
  assign wb_en    = bus.wb_valid_i && reset;
  assign issue_en = bus.issue_valid_i && reset;

  // Next state: data write, then scoreboard with flush > issue > write-back.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en && (bus.wb_rd_i != '0)) begin
      regs_d[bus.wb_rd_i] = bus.wb_data_i;
      busy_d[bus.wb_rd_i] = 1'b0;
    end
    if (issue_en && (bus.issue_rd_i != '0)) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
    if (bus.flush_i) begin
      busy_d = '0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    busy_count_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy_count_d = busy_count_d + CW'(busy_d[r]);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Read ports; a forwarded write-back also reports not-busy unless re-issued.
  always_comb begin
    rd_data_c = '0;
    rs_busy_c = '0;
    rs_sel    = '0;
    wb_hit    = 1'b0;
    issue_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rs_sel    = bus.rs_i[k*AW +: AW];
      wb_hit    = (BYPASS != 0) && wb_en && (bus.wb_rd_i == rs_sel) && (rs_sel != '0);
      issue_hit = issue_en && (bus.issue_rd_i == rs_sel);
      if (rs_sel == '0) begin
        rd_data_c[k*XLEN +: XLEN] = '0;
        rs_busy_c[k]              = 1'b0;
      end else begin
        rd_data_c[k*XLEN +: XLEN] = wb_hit ? bus.wb_data_i : regs_q[rs_sel];
        rs_busy_c[k]              = (wb_hit && !issue_hit) ? 1'b0 : busy_q[rs_sel];
      end
    end
  end

  assign bus.rd_data_o    = rd_data_c;
  assign bus.rs_busy_o    = rs_busy_c;
  assign bus.busy_count_o = busy_count_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a built-in write-back scoreboard. It is the successor to the fixed 32x32, two-read-port decode register fetch. Width, depth and read-port count are configurable, and it adds a real write port, same-cycle write-through bypass, and per-register busy tracking. It sits in decode: read ports feed the operand latches, the write port is driven by write-back, and the issue logic sets busy bits.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; a power of two and at least 2; register 0 is hardwired to zero
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = a same-cycle write-back value is forwarded to reads; 0 = reads see only stored state
(localparam AW = $clog2(NREGS))

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
rs_i  input  NUM_RD*AW  read-select addresses; port k uses bits [k*AW +: AW]
rd_data_o  output  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rs_busy_o  output  NUM_RD  1 = the register selected by port k has a pending write
wb_valid_i  input  1  write-back strobe
wb_rd_i  input  AW  write-back destination
wb_data_i  input  XLEN  write-back data
issue_valid_i  input  1  an instruction writing issue_rd_i is issued this cycle
issue_rd_i  input  AW  destination of the issued instruction
flush_i  input  1  clears all busy bits (pipeline flush)
busy_count_o  output  AW+1  number of registers currently busy

Behaviour:
- Reset (reset low, asynchronous, takes effect immediately without a clock edge): all registers cleared to 0, all busy bits cleared. Outputs settle to rd_data_o = 0, rs_busy_o = 0, busy_count_o = 0. While reset is held low, all strobes are ignored. First writes are accepted on the first rising edge after reset deasserts.
- Register 0: never written; its busy bit is never set. Reads of address 0 always return 0 with busy 0, including when wb_rd_i = 0 or issue_rd_i = 0.
- Write: on a rising edge with wb_valid_i = 1 and wb_rd_i != 0, reg[wb_rd_i] <= wb_data_i. Write-to-read latency through storage is 1 cycle.
- Read: combinational from rs_i and stored state. All NUM_RD ports are independent; any number of ports may select the same address.
- Bypass (BYPASS = 1): if wb_valid_i = 1, wb_rd_i = rs_k and rs_k != 0, then rd_data_o[k] = wb_data_i in the same cycle. With BYPASS = 0, the old stored value is returned until the next cycle.
- Scoreboard next-state, per register r != 0, evaluated in priority order:
  - flush_i = 1 → busy = 0. Flush beats both write-back and issue on the same edge. A write-back in the flush cycle still updates data.
  - issue_valid_i = 1 and issue_rd_i = r → busy = 1. Issue beats a write-back to the same r in the same cycle: data is written and busy stays 1, because the new producer is still outstanding.
  - wb_valid_i = 1 and wb_rd_i = r → busy = 0.
  - otherwise → hold.
- A write-back to a non-busy register is legal: data is written and busy stays 0.
- rs_busy_o[k] = busy[rs_k], except when all three hold: BYPASS = 1, a same-cycle write-back targets rs_k, and no same-cycle issue targets rs_k. In that case it reads 0. With BYPASS = 0 it is the stored busy bit.
- busy_count_o = population count of the stored busy bits, registered state only, so it updates the cycle after a change. Its range is 0..NREGS-1, so no overflow is possible.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset check: hold reset low mid-run after writing reg5 = 32'hDEADBEEF → all reads 0 immediately with no clock edge, busy_count_o = 0. After release, reading reg5 returns 0.
- Write/read with BYPASS = 0: write reg3 = 32'h1234_5678 at edge N. At N, rs_i[0] = 3 reads the old value 0; from N+1 it reads 32'h12345678. Simultaneously rs_i[1] = 3 returns the same value.
- Bypass with BYPASS = 1: wb to reg7 with 32'hA5A5A5A5 while rs_i[1] = 7 → rd_data_o[1] = 32'hA5A5A5A5 in the same cycle. Write to reg0 with 32'hFFFFFFFF → reading reg0 returns 0 before and after.
- Scoreboard: issue reg9 → rs_busy 1 and busy_count 1 from the next cycle. wb reg9 → busy 0 the next cycle; with BYPASS = 1, rs_busy for 9 already reads 0 in the wb cycle.
- Simultaneous issue + wb to reg4: reg4 is busy beforehand; issue 4 and wb 4 with 32'h55 on the same edge → data is 32'h55, busy[4] stays 1, busy_count unchanged.
- Flush: issue reg1, reg2 and reg31 in consecutive cycles (busy_count = 3). flush_i together with issue reg10 → all busy 0 next cycle, busy_count = 0.
